// File: rtl/aclk_pkg.sv
// aclk_pkg: shared types and constants for the alarm-clock setting front end.
//   aclk_set_state_t : setting FSM states
//   aclk_field_t     : edit_field encoding (display blink select)
//   aclk_time_t      : BCD hh:mm as carried on the H_in*/M_in* bus
//   bcd_hour_inc / bcd_min_inc : wrap-around BCD increment helpers
package aclk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T_HOUR,
    ST_T_MIN,
    ST_A_HOUR,
    ST_A_MIN,
    ST_LOAD
  } aclk_set_state_t;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HOUR = 2'd1,
    FIELD_MIN  = 2'd2
  } aclk_field_t;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } aclk_time_t;

  localparam logic [1:0] HOUR_MAX_H1 = 2'd2;
  localparam logic [3:0] HOUR_MAX_H0 = 4'd3;
  localparam logic [3:0] MIN_MAX_M1  = 4'd5;
  localparam logic [3:0] DIGIT_MAX   = 4'd9;

  // Index of each button in the debouncer instance array
  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;
  localparam int BTN_SET  = 2;

  // 23 -> 00, x9 -> (x+1)0, otherwise units +1. Minutes untouched.
  function automatic aclk_time_t bcd_hour_inc(input aclk_time_t t);
    aclk_time_t r;
    r = t;
    if (t.h1 == HOUR_MAX_H1 && t.h0 == HOUR_MAX_H0) begin
      r.h1 = 2'd0;
      r.h0 = 4'd0;
    end else if (t.h0 == DIGIT_MAX) begin
      r.h1 = t.h1 + 2'd1;
      r.h0 = 4'd0;
    end else begin
      r.h0 = t.h0 + 4'd1;
    end
    return r;
  endfunction

  // 59 -> 00, x9 -> (x+1)0, otherwise units +1. Hours untouched.
  function automatic aclk_time_t bcd_min_inc(input aclk_time_t t);
    aclk_time_t r;
    r = t;
    if (t.m1 == MIN_MAX_M1 && t.m0 == DIGIT_MAX) begin
      r.m1 = 4'd0;
      r.m0 = 4'd0;
    end else if (t.m0 == DIGIT_MAX) begin
      r.m1 = t.m1 + 4'd1;
      r.m0 = 4'd0;
    end else begin
      r.m0 = t.m0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/aclk_debounce.sv
// aclk_debounce: one push-button path.
//   2-flop synchroniser -> consecutive-sample debounce counter -> rise pulse.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_raw          : raw asynchronous button level
//   o_level        : debounced level
//   o_press        : one-cycle pulse, registered, one cycle after o_level rises
module aclk_debounce
  import aclk_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);

  logic          r_sync1, r_sync2;
  logic          r_level, r_level_d, r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Count consecutive samples that disagree with the accepted level;
      // any agreeing sample restarts the run.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/aclk_set_ctrl.sv
// aclk_set_ctrl: button front end and setting FSM for the alarm-clock core.
//   Debounces mode/inc/set, lets the operator edit time or alarm in BCD and
//   loads the result into the core with LD strobes held LD_HOLD cycles so
//   the core's divided 1 s clock always sees them.
// Build option: define AUTO_REPEAT_EN to get auto-repeat on a held inc
//   button (REPEAT_DLY then every REPEAT_RATE cycles). Undefined: one inc
//   event per press and no repeat counter.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   btn_mode, btn_inc, btn_set    : raw buttons, active-high
//   cur_h1/cur_h0/cur_m1/cur_m0   : current time from the core (BCD)
//   H_in1/H_in0/M_in1/M_in0       : edit registers to the core (BCD)
//   LD_time, LD_alarm             : stretched load strobes
//   set_active                    : high in any edit or LOAD state
//   edit_field                    : 0 none, 1 hour, 2 minute
module aclk_set_ctrl
  import aclk_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int LD_HOLD      = 16,
  parameter int TIMEOUT_CYC  = 255,
  parameter int REPEAT_DLY   = 20,
  parameter int REPEAT_RATE  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_set,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       set_active,
  output logic [1:0] edit_field
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(LD_HOLD + 1);

  // ---------------------------------------------------------------- buttons
  logic [2:0] w_raw, w_level, w_press;
  logic       w_rpt;
  logic       w_unused_lvl;

  assign w_raw[BTN_MODE] = btn_mode;
  assign w_raw[BTN_INC]  = btn_inc;
  assign w_raw[BTN_SET]  = btn_set;

  aclk_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db [2:0] (
    .i_clk   (clk),
    .i_reset (reset),
    .i_raw   (w_raw),
    .o_level (w_level),
    .o_press (w_press)
  );

  // Debounced levels are only needed for auto-repeat; repeat timing params
  // are likewise dead in the default build.
  assign w_unused_lvl = ^{w_level, REPEAT_DLY[0], REPEAT_RATE[0]};

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY + 1);
  logic [RW-1:0] r_rpt_cnt;
  logic          r_rpt;

  // r_rpt_cnt counts cycles the debounced inc level has been high. The
  // first repeat lines up REPEAT_DLY cycles after the press pulse; reloading
  // to DLY-RATE+1 spaces the rest REPEAT_RATE apart. Repeats outside edit
  // states are harmless since the FSM ignores inc there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rpt_cnt <= '0;
      r_rpt     <= 1'b0;
    end else if (!w_level[BTN_INC]) begin
      r_rpt_cnt <= '0;
      r_rpt     <= 1'b0;
    end else if (r_rpt_cnt == RW'(REPEAT_DLY)) begin
      r_rpt_cnt <= RW'(REPEAT_DLY - REPEAT_RATE + 1);
      r_rpt     <= 1'b1;
    end else begin
      r_rpt_cnt <= r_rpt_cnt + RW'(1);
      r_rpt     <= 1'b0;
    end
  end

  assign w_rpt = r_rpt;
`else
  assign w_rpt = 1'b0;
`endif

  // Priority set > mode > inc is resolved by the if/else order in the FSM.
  logic w_ev_set, w_ev_mode, w_ev_inc, w_any_ev;
  assign w_ev_set  = w_press[BTN_SET];
  assign w_ev_mode = w_press[BTN_MODE];
  assign w_ev_inc  = w_press[BTN_INC] | w_rpt;
  assign w_any_ev  = w_ev_set | w_ev_mode | w_ev_inc;

  // -------------------------------------------------------------------- FSM
  aclk_set_state_t r_state;
  aclk_field_t     r_field;
  aclk_time_t      r_edit, r_shadow;
  aclk_time_t      w_cur, w_hour_inc, w_min_inc;
  logic            r_tgt_alarm;
  logic            r_ld_time, r_ld_alarm, r_set_active;
  logic [TW-1:0]   r_to_cnt;
  logic [LW-1:0]   r_ld_cnt;
  logic            w_in_hour;

  assign w_cur      = {cur_h1, cur_h0, cur_m1, cur_m0};
  assign w_hour_inc = bcd_hour_inc(r_edit);
  assign w_min_inc  = bcd_min_inc(r_edit);
  assign w_in_hour  = (r_state == ST_T_HOUR) || (r_state == ST_A_HOUR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_field      <= FIELD_NONE;
      r_edit       <= '0;
      r_shadow     <= '0;
      r_tgt_alarm  <= 1'b0;
      r_ld_time    <= 1'b0;
      r_ld_alarm   <= 1'b0;
      r_set_active <= 1'b0;
      r_to_cnt     <= '0;
      r_ld_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_to_cnt <= '0;
          if (w_ev_set) begin
            r_state      <= ST_A_HOUR;
            r_tgt_alarm  <= 1'b1;
            r_edit       <= r_shadow;
            r_set_active <= 1'b1;
            r_field      <= FIELD_HOUR;
          end else if (w_ev_mode) begin
            r_state      <= ST_T_HOUR;
            r_tgt_alarm  <= 1'b0;
            r_edit       <= w_cur;
            r_set_active <= 1'b1;
            r_field      <= FIELD_HOUR;
          end
        end

        ST_T_HOUR, ST_T_MIN, ST_A_HOUR, ST_A_MIN: begin
          if (w_any_ev) r_to_cnt <= '0;
          else          r_to_cnt <= r_to_cnt + TW'(1);

          if (w_ev_set) begin
            r_state  <= ST_LOAD;
            r_field  <= FIELD_NONE;
            r_ld_cnt <= '0;
            r_to_cnt <= '0;
            if (r_tgt_alarm) begin
              r_ld_alarm <= 1'b1;
              r_shadow   <= r_edit;
            end else begin
              r_ld_time <= 1'b1;
            end
          end else if (w_ev_mode) begin
            if (w_in_hour) begin
              r_state <= r_tgt_alarm ? ST_A_MIN : ST_T_MIN;
              r_field <= FIELD_MIN;
            end else begin
              r_state <= r_tgt_alarm ? ST_A_HOUR : ST_T_HOUR;
              r_field <= FIELD_HOUR;
            end
          end else if (w_ev_inc) begin
            r_edit <= w_in_hour ? w_hour_inc : w_min_inc;
          end else if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            // Abandon the edit; edit registers keep their value.
            r_state      <= ST_IDLE;
            r_field      <= FIELD_NONE;
            r_set_active <= 1'b0;
            r_to_cnt     <= '0;
          end
        end

        ST_LOAD: begin
          // Buttons are ignored here; the strobe falls on the same edge
          // that returns to IDLE.
          if (r_ld_cnt == LW'(LD_HOLD - 1)) begin
            r_state      <= ST_IDLE;
            r_ld_time    <= 1'b0;
            r_ld_alarm   <= 1'b0;
            r_set_active <= 1'b0;
            r_ld_cnt     <= '0;
          end else begin
            r_ld_cnt <= r_ld_cnt + LW'(1);
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_field      <= FIELD_NONE;
          r_ld_time    <= 1'b0;
          r_ld_alarm   <= 1'b0;
          r_set_active <= 1'b0;
        end
      endcase
    end
  end

  assign {H_in1, H_in0, M_in1, M_in0} = r_edit;
  assign LD_time    = r_ld_time;
  assign LD_alarm   = r_ld_alarm;
  assign set_active = r_set_active;
  assign edit_field = r_field;

endmodule
